dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised data memory for the RV32 core with RISC-V sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW), byte-lane writes, alignment and range checking, and a valid/ready request port with a registered one-cycle response. On reset it zeroes the array with a hardware scrub state machine, one word per cycle, instead of clearing every word in a single cycle. It sits between the core's memory stage and the word-addressed storage, as the next generation of the core's data memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- SCRUB_ON_RESET, 1: 1 = zero the array after reset; 0 = skip scrub, ready right after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response valid; one-cycle pulse per accepted request.
- rsp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range or illegal funct3.
- busy  out  1  scrub in progress.

## Operation
- A request is accepted when req_valid and req_ready are both 1. req_ready is 1 exactly in state READY and is independent of req_valid.
- The word index is req_addr[IDX_W+1:2], with IDX_W = log2(DEPTH_WORDS). The address is out of range when req_addr[31:IDX_W+2] is not 0.
- Loads decode req_funct3 as:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - 011, 110, 111: illegal.
- Stores decode req_funct3 as 000 SB, 001 SH, 010 SW. Every other value is illegal.
- Byte lane selection:
  - Byte access: lane = addr[1:0].
  - Half access: lanes {2*addr[1], 2*addr[1]+1}; misaligned if addr[0] = 1.
  - Word access: all lanes; misaligned if addr[1:0] is not 0.
- Stores write only the selected lanes. SB places wdata[7:0] in lane k. SH places wdata[15:0] in the selected lane pair.
- Error requests (misaligned, out of range or illegal funct3) do not modify memory. They produce rsp_valid=1, rsp_err=1, rsp_rdata=0.
- A successful store response is rsp_valid=1, rsp_err=0, rsp_rdata=0.
- FSM states SCRUB and READY:
  - Reset asserted: state=SCRUB, scrub_cnt=0 (when SCRUB_ON_RESET=0, state=READY).
  - In SCRUB, each cycle writes 0 to word scrub_cnt and increments scrub_cnt. After writing word DEPTH_WORDS-1 the state moves to READY.
  - READY persists until the next reset.
- Reset asserted mid-scrub restarts the scrub at word 0.
- Reset asserted mid-request drops the pending response: rsp_valid is 0 after reset.
- The array itself is not asynchronously reset. Only the FSM, the counter and the outputs are.

## Timing
- Values after reset: req_ready=0 (1 when SCRUB_ON_RESET=0), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=SCRUB_ON_RESET.
- Scrub duration is exactly DEPTH_WORDS cycles after reset deasserts. busy falls and req_ready rises on the same edge.
- Latency: a request accepted at edge N gets its response valid in the cycle after edge N+1, for one cycle.
- Throughput is one request per cycle, back to back, with no bubbles. There is no backpressure on the response.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data.
- A store does not alter its own response data.

## Structure
- Package dmem_pkg holds:
  - state_t {SCRUB, READY};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function lane_mask(funct3, addr[1:0]) returning a 4-bit mask;
  - function load_extend(word, funct3, addr[1:0]).
- Sub-module dmem_lane_ram: DEPTH_WORDS x 32 synchronous-read RAM with a 4-bit byte write enable and one read/write port.
  - The FSM muxes the scrub write port ahead of the request port.

## Test plan
- Reset with DEPTH_WORDS=16 -> busy=1 for exactly 16 cycles after reset deasserts, then req_ready=1. A subsequent LW of each word returns 0.
- SW 0x11223344 @0x8, then LB @0x9 -> 0x00000033; LH @0xA -> 0x00001122; LBU @0xB -> 0x00000011.
- SW 0x000080FF @0x4, then LB @0x4 -> 0xFFFFFFFF; LBU @0x4 -> 0x000000FF; LH @0x4 -> 0xFFFF80FF; LHU @0x4 -> 0x000080FF.
- SW 0xAABBCCDD @0x0, SB 0x5A @0x2, SH 0x1234 @0x0 back to back, then LW @0x0 -> 0xAA5A1234. Each response arrives one cycle after acceptance.
- Error cases, each checked with a following LW of the target word showing it unchanged:
  - LW @0x6 -> rsp_err=1, rdata 0.
  - SH @0x3 -> rsp_err=1, no write.
  - funct3=011 load -> rsp_err=1.
  - LW @0x40 with DEPTH_WORDS=16 -> rsp_err=1.
- Reset pulsed at scrub cycle 5 -> scrub restarts and busy lasts a full DEPTH_WORDS cycles. Reset pulsed with a load in flight -> no rsp_valid after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and lane helpers for the data memory LSU.
package dmem_pkg;

  typedef enum logic {
    SCRUB,
    READY
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access; funct3[1:0] encodes the size.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    m = '0;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Select the addressed byte/half from a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      F3_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Single-port synchronous-read RAM with per-byte write enables (read-first).
module dmem_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read of the same word.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with sub-word load/store, error checking and reset scrub.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter bit          SCRUB_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t           state;
  logic [IDX_W-1:0] scrub_cnt;

  logic             accept, f3_ok, misalign, range_err, req_err;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata, ram_rdata, store_data;

  logic             p_valid, p_err, p_we;
  logic [2:0]       p_f3;
  logic [1:0]       p_off;

  assign req_ready = (state == READY);
  assign busy      = (state == SCRUB);
  assign accept    = req_valid && req_ready;

  // Request decode: legality, alignment, range and lane-replicated store data.
  always_comb begin
    if (req_we) f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W});
    else        f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    range_err = |req_addr[31:IDX_W+2];
    req_err   = !f3_ok || misalign || range_err;
    case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  // RAM port mux: scrub writes take the port until the array is cleared.
  always_comb begin
    if (state == SCRUB) begin
      ram_addr  = scrub_cnt;
      ram_be    = '1;
      ram_wdata = '0;
    end else begin
      ram_addr  = req_addr[IDX_W+1:2];
      ram_be    = (accept && req_we && !req_err) ? lane_mask(req_funct3, req_addr[1:0]) : '0;
      ram_wdata = store_data;
    end
  end

  dmem_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Scrub/ready FSM: one word cleared per cycle, then ready until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCRUB_ON_RESET ? SCRUB : READY;
      scrub_cnt <= '0;
    end else if (state == SCRUB) begin
      scrub_cnt <= scrub_cnt + 1'b1;
      if (scrub_cnt == LAST_IDX) state <= READY;
    end
  end

  // Two-stage response: capture request beside the RAM read, then format.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid   <= 1'b0;
      p_err     <= 1'b0;
      p_we      <= 1'b0;
      p_f3      <= '0;
      p_off     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      p_valid   <= accept;
      p_err     <= req_err;
      p_we      <= req_we;
      p_f3      <= req_funct3;
      p_off     <= req_addr[1:0];
      rsp_valid <= p_valid;
      rsp_err   <= p_valid && p_err;
      rsp_rdata <= (p_valid && !p_err && !p_we) ? load_extend(ram_rdata, p_f3, p_off) : '0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed self-checking bench for dmem_lsu (16-word instance).
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_lsu #(
    .DEPTH_WORDS   (DEPTH),
    .SCRUB_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory and a queue of expected responses.
  logic [7:0] mem_b [BYTES];

  typedef struct {
    int unsigned due;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t q[$];

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned size;
    bit          legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    size  = 1 << f3[1:0];
    err   = !legal || (a % size) != 0 || a >= BYTES;
    rd    = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mem_b[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(size); i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  // Response monitor: every cycle outside reset, rsp_valid must match the scoreboard.
  bit ev;
  always @(negedge clk) begin
    if (!reset) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_rdata", rsp_rdata, q[0].rd);
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    model(we, f3, a, wd, e.rd, e.err);
    e.due = cyc + 1;
    q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Release reset and measure how many edges busy stays high.
  task automatic release_and_scrub(input string tag);
    int n = 0;
    reset = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_scrub_len"}, n, DEPTH);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    for (int i = 0; i < int'(BYTES); i++) mem_b[i] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    release_and_scrub("por");

    // Every word reads back zero after scrub.
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, 3'b010, 32'(4 * i), '0);

    issue(1'b1, 3'b010, 32'h8, 32'h11223344);
    issue(1'b0, 3'b000, 32'h9, '0);
    issue(1'b0, 3'b001, 32'hA, '0);
    issue(1'b0, 3'b100, 32'hB, '0);

    issue(1'b1, 3'b010, 32'h4, 32'h000080FF);
    issue(1'b0, 3'b000, 32'h4, '0);
    issue(1'b0, 3'b100, 32'h4, '0);
    issue(1'b0, 3'b001, 32'h4, '0);
    issue(1'b0, 3'b101, 32'h4, '0);

    issue(1'b1, 3'b010, 32'h0, 32'hAABBCCDD);
    issue(1'b1, 3'b000, 32'h2, 32'hFFFFFF5A);
    issue(1'b1, 3'b001, 32'h0, 32'hFFFF1234);
    issue(1'b0, 3'b010, 32'h0, '0);
    idle(1);

    // Error requests, each followed by a read of the targeted word.
    issue(1'b0, 3'b010, 32'h6, '0);
    issue(1'b0, 3'b010, 32'h4, '0);
    issue(1'b1, 3'b001, 32'h3, 32'hDEAD);
    issue(1'b0, 3'b010, 32'h0, '0);
    issue(1'b0, 3'b011, 32'h0, '0);
    issue(1'b0, 3'b010, 32'h0, '0);
    issue(1'b0, 3'b010, 32'h40, '0);
    issue(1'b1, 3'b010, 32'h40, 32'h55AA55AA);
    issue(1'b1, 3'b011, 32'h0, 32'h12345678);
    issue(1'b1, 3'b010, 32'h80000000, 32'h0BADF00D);
    issue(1'b0, 3'b010, 32'h0, '0);
    idle(2);

    // Randomized traffic, mostly in range, with occasional bubbles.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Reset at scrub cycle 5 restarts the full scrub.
    reset = 1'b1;
    q.delete();
    idle(2);
    check_reset_outputs("rst2");
    reset = 1'b0;
    idle(5);
    chk("mid_scrub_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    idle(1);
    release_and_scrub("restart");
    issue(1'b0, 3'b010, 32'h8, '0);
    idle(3);

    // Reset with a load in flight drops its response.
    issue(1'b1, 3'b010, 32'hC, 32'hCAFEBABE);
    issue(1'b0, 3'b010, 32'hC, '0);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("inflight_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("inflight_rsp_valid2", 32'(rsp_valid), 32'd0);
    release_and_scrub("inflight");
    issue(1'b0, 3'b010, 32'hC, '0);
    idle(4);

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
